// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
// Instruction fetch stage placed just before the instruction decoder. It holds
// the program counter and reads one byte per cycle from a synchronous program
// ROM. It presents each byte to the decoder as inst_en/inst. It also handles
// jumps, downstream stalls and start/halt control, and discards or re-reads
// in-flight bytes when needed.
//
// Ports
//   clk        system clock, all logic on posedge
//   rst        synchronous reset, active-high
//   start      pulse, IDLE -> RUN
//   halt_req   pulse, RUN -> IDLE (resumable, no byte lost)
//   stall      level, downstream cannot accept a byte this cycle
//   jump_en    pulse, load PC from jump_addr
//   jump_addr  jump target
//   rom_addr   ROM read address (= pc)
//   rom_data   ROM read data, valid one cycle after rom_addr
//   inst_en    inst is valid and consumed this cycle
//   inst       instruction/data byte (= rom_data)
//   busy       1 while in RUN
//   inst_cnt   bytes issued since reset, saturating
// ---------------------------------------------------------------------------
module inst_fetch #(
   parameter int unsigned       ADDR_W     = 10,
   parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              halt_req,
   input  logic              stall,
   input  logic              jump_en,
   input  logic [ADDR_W-1:0] jump_addr,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [7:0]        rom_data,
   output logic              inst_en,
   output logic [7:0]        inst,
   output logic              busy,
   output logic [15:0]       inst_cnt
);

   localparam int unsigned CNT_W = 16;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] pc;    // next read address
   logic [ADDR_W-1:0] ipc;   // address of the byte currently on rom_data
   logic              pend;  // rom_data holds a valid, unflushed byte

   // The ROM is read directly from the PC. The byte goes straight to the decoder.
   assign rom_addr = pc;
   assign inst     = rom_data;
   assign busy     = (state == RUN);
   assign inst_en  = (state == RUN) & pend & ~stall & ~jump_en & ~halt_req;

   // Fetch control, PC tracking and issue counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         pc       <= START_ADDR;
         ipc      <= START_ADDR;
         pend     <= 1'b0;
         inst_cnt <= '0;
      end else begin
         if (inst_en && (inst_cnt != {CNT_W{1'b1}}))
            inst_cnt <= inst_cnt + CNT_W'(1);

         case (state)
            IDLE: begin
               pend <= 1'b0;
               if (jump_en)
                  pc <= jump_addr;
               if (start)
                  state <= RUN;
            end
            RUN: begin
               if (jump_en) begin
                  // Drop the in-flight byte and restart from the target
                  pc   <= jump_addr;
                  pend <= 1'b0;
               end else if (halt_req) begin
                  // Rewind to the unissued byte so that resuming loses nothing
                  pc    <= pend ? ipc : pc;
                  pend  <= 1'b0;
                  state <= IDLE;
               end else if (stall) begin
                  // Re-read the unconsumed byte once the stall is released
                  pc   <= pend ? ipc : pc;
                  pend <= 1'b0;
               end else begin
                  ipc  <= pc;
                  pc   <= pc + ADDR_W'(1);
                  pend <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               pend  <= 1'b0;
            end
         endcase
      end
   end

endmodule
